// File: rtl/shift_mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per falling clock edge,
// LSB first, with optional two's-complement mode and a held result register.
`timescale 1ns/1ps
module shift_mult_seq #(
  parameter int unsigned WIDTH          = 8,
  parameter bit          SIGNED_SUPPORT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             smode;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    step;

  logic             smode_in_c;
  logic             last_c;
  logic [WIDTH:0]   a_ext_c;
  logic [WIDTH:0]   pp_c;
  logic [WIDTH+1:0] full_c;
  logic [WIDTH:0]   sum_c;
  logic             fill_c;
  logic [AW-1:0]    acc_nxt_c;
  logic             unused_c;

  // Unsigned-only builds ignore the runtime mode input entirely.
  assign smode_in_c = SIGNED_SUPPORT ? signed_mode : 1'b0;

  // Bit 0 of the accumulator is shifted out and never needed again.
  assign unused_c = acc[0];

  // One add-and-shift step; the final signed step subtracts the multiplicand
  // because the multiplier MSB carries negative weight.
  always_comb begin
    last_c  = (step == LAST_STEP);
    a_ext_c = {smode & a_reg[WIDTH-1], a_reg};
    pp_c    = '0;
    if (b_reg[0]) begin
      pp_c = (smode && last_c) ? -a_ext_c : a_ext_c;
    end
    full_c    = {smode & acc[AW-1], acc[AW-1:WIDTH]} + {smode & pp_c[WIDTH], pp_c};
    sum_c     = full_c[WIDTH:0];
    fill_c    = smode ? full_c[WIDTH] : full_c[WIDTH+1];
    acc_nxt_c = {fill_c, sum_c, acc[WIDTH-1:1]};
  end

  // Control FSM and datapath registers, updated on the falling clock edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      smode <= 1'b0;
      acc   <= '0;
      step  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            smode <= smode_in_c;
            acc   <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt_c;
          b_reg <= b_reg >> 1;
          step  <= step + CW'(1);
          if (last_c) begin
            y     <= acc_nxt_c[PW-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mult_seq.sv
// Bench for shift_mult_seq: five instances (directed W=8 signed, directed
// W=16 unsigned-only, random W=4/8/13) with a transaction-level predictor
// feeding a scoreboard queue and a done-driven monitor per instance.
`timescale 1ns/1ps
module tb_shift_mult_seq;

  localparam int unsigned NDUT = 5;
  localparam int unsigned WS  [NDUT] = '{8, 16, 4, 8, 13};
  localparam bit          SSS [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam int unsigned NCYC = 24000;

  logic        clk;
  logic        rst_n;
  logic        rst8_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        all_done = 1'b0;
  logic        rnd_fin  = 1'b0;

  logic        ds_start [2];
  logic        ds_sm    [2];
  logic [31:0] ds_a     [2];
  logic [31:0] ds_b     [2];
  logic        rs_start [3];
  logic        rs_sm    [3];
  logic [31:0] rs_a     [3];
  logic [31:0] rs_b     [3];

  logic        busy_s [NDUT];
  logic        done_s [NDUT];
  logic [63:0] y_s    [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts DUT active (falling) edges; read on rising edges only.
  always @(negedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Exact product from plain integer arithmetic, masked to 2*w bits.
  function automatic longint unsigned ref_mul(input int unsigned w, input bit sg,
                                              input longint unsigned av, input longint unsigned bv);
    longint unsigned m;
    longint          sa;
    longint          sb;
    m  = (64'd1 << w) - 64'd1;
    sa = $signed(av & m);
    sb = $signed(bv & m);
    if (sg && av[w-1]) sa = sa - $signed(64'd1 << w);
    if (sg && bv[w-1]) sb = sb - $signed(64'd1 << w);
    return $unsigned(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [31:0] pick(input int unsigned w);
    logic [31:0] one;
    one = 32'd1;
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return one << (w - 1);
      3:       return (one << (w - 1)) - 32'd1;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = WS[g];
    logic            start_l;
    logic            sm_l;
    logic            rst_l;
    logic [31:0]     a_l;
    logic [31:0]     b_l;
    logic [2*W-1:0]  yl;
    longint unsigned qy[$];
    int unsigned     qt[$];
    int unsigned     free_at = 0;
    longint unsigned ey;
    int unsigned     et;

    if (g < 2) begin : g_d
      assign start_l = ds_start[g];
      assign sm_l    = ds_sm[g];
      assign a_l     = ds_a[g];
      assign b_l     = ds_b[g];
    end else begin : g_r
      assign start_l = rs_start[g-2];
      assign sm_l    = rs_sm[g-2];
      assign a_l     = rs_a[g-2];
      assign b_l     = rs_b[g-2];
    end
    assign rst_l = (g == 0) ? rst8_n : rst_n;

    shift_mult_seq #(.WIDTH(W), .SIGNED_SUPPORT(SSS[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_l),
      .start      (start_l),
      .signed_mode(sm_l),
      .a          (a_l[W-1:0]),
      .b          (b_l[W-1:0]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .y          (yl)
    );
    assign y_s[g] = 64'(yl);

    // Predictor: a request is taken at the next edge when idle; busy for W edges.
    initial forever begin
      @(posedge clk);
      if (!rst_l) begin
        qy.delete();
        qt.delete();
        free_at = 0;
      end else begin
        chk($sformatf("busy[%0d]", g), 64'(busy_s[g]), 64'(cyc < free_at));
        if (start_l && cyc >= free_at) begin
          qy.push_back(ref_mul(W, sm_l && SSS[g], 64'(a_l), 64'(b_l)));
          qt.push_back(cyc + 1 + W);
          free_at = cyc + 1 + W;
        end
      end
    end

    // Monitor: every done pulse must match the oldest outstanding request.
    initial forever begin
      @(posedge clk);
      if (rst_l && done_s[g]) begin
        if (qy.size() == 0) begin
          chk($sformatf("done_unexpected[%0d]", g), 64'(done_s[g]), 64'd0);
        end else begin
          ey = qy.pop_front();
          et = qt.pop_front();
          chk($sformatf("y[%0d]", g), y_s[g], ey);
          chk($sformatf("done_edge[%0d]", g), 64'(cyc), 64'(et));
        end
      end
    end

    initial begin
      wait (all_done);
      chk($sformatf("pending[%0d]", g), 64'(qy.size()), 64'd0);
    end
  end

  task automatic issue(input int g, input logic [31:0] av, input logic [31:0] bv, input logic m);
    @(negedge clk); #1;
    ds_start[g] = 1'b1;
    ds_a[g]     = av;
    ds_b[g]     = bv;
    ds_sm[g]    = m;
    @(negedge clk); #1;
    ds_start[g] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Random traffic on the three regression instances; operands change freely
  // while busy and start is often asserted during a run.
  initial begin
    for (int i = 0; i < 3; i++) begin
      rs_start[i] = 1'b0; rs_sm[i] = 1'b0; rs_a[i] = '0; rs_b[i] = '0;
    end
    wait (rst_n === 1'b1);
    repeat (NCYC) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        rs_start[i] = ($urandom_range(3) != 0);
        rs_sm[i]    = 1'($urandom_range(1));
        rs_a[i]     = pick(WS[i+2]);
        rs_b[i]     = pick(WS[i+2]);
      end
    end
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) rs_start[i] = 1'b0;
    repeat (20) @(negedge clk);
    rnd_fin = 1'b1;
  end

  // Directed sequence on the W=8 and W=16 instances.
  initial begin
    logic found;
    rst_n  = 1'b0;
    rst8_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ds_start[i] = 1'b0; ds_sm[i] = 1'b0; ds_a[i] = '0; ds_b[i] = '0;
    end
    repeat (3) @(negedge clk); #1;
    chk("reset_busy", 64'(busy_s[0]), 64'd0);
    chk("reset_done", 64'(done_s[0]), 64'd0);
    chk("reset_y", y_s[0], 64'd0);
    rst_n  = 1'b1;
    rst8_n = 1'b1;

    // Unsigned full-scale product, then y must hold.
    issue(0, 32'hFF, 32'hFF, 1'b0);
    repeat (8) @(negedge clk);
    repeat (10) @(negedge clk); #1;
    chk("hold_y", y_s[0], 64'hFE01);
    chk("hold_done", 64'(done_s[0]), 64'd0);

    // Signed corner cases.
    issue(0, 32'h80, 32'h80, 1'b1); repeat (8) @(negedge clk);
    issue(0, 32'hFF, 32'h7F, 1'b1); repeat (8) @(negedge clk);
    issue(0, 32'h05, 32'hFD, 1'b1); repeat (8) @(negedge clk);

    // start held high: back-to-back products every WIDTH+1 edges.
    @(negedge clk); #1;
    ds_start[0] = 1'b1; ds_a[0] = 32'h37; ds_b[0] = 32'hC9; ds_sm[0] = 1'b1;
    repeat (27) @(negedge clk); #1;
    ds_start[0] = 1'b0;
    repeat (10) @(negedge clk);

    // A second start during the run is dropped.
    issue(0, 32'h9A, 32'h65, 1'b0);
    repeat (2) @(negedge clk); #1;
    ds_start[0] = 1'b1; ds_a[0] = 32'h11; ds_b[0] = 32'h22;
    @(negedge clk); #1;
    ds_start[0] = 1'b0;
    repeat (8) @(negedge clk);

    // start in the done cycle is accepted.
    issue(0, 32'h12, 32'h34, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (done_s[0]) found = 1'b1;
    end
    chk("done_seen", 64'(found), 64'd1);
    ds_start[0] = 1'b1; ds_a[0] = 32'hC3; ds_b[0] = 32'h81; ds_sm[0] = 1'b1;
    @(negedge clk); #1;
    ds_start[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of a run clears outputs immediately.
    issue(0, 32'hAB, 32'hCD, 1'b0);
    repeat (3) @(negedge clk); #2;
    rst8_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_s[0]), 64'd0);
    chk("abort_done", 64'(done_s[0]), 64'd0);
    chk("abort_y", y_s[0], 64'd0);
    repeat (2) @(negedge clk); #1;
    rst8_n = 1'b1;
    repeat (12) @(negedge clk); #1;
    chk("abort_y_later", y_s[0], 64'd0);

    // Unsigned-only build ignores signed_mode.
    issue(1, 32'hFFFF, 32'hFFFF, 1'b1); repeat (16) @(negedge clk);
    issue(1, 32'h0, 32'h1234, 1'b0);    repeat (18) @(negedge clk);

    wait (rnd_fin);
    all_done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
